// File: rtl/mccu_pkg.sv
// Shared definitions for the MCCU budget sequencer: FSM encoding and default widths.
package mccu_pkg;

    localparam int MCCU_STATE_W  = 2;
    localparam int MCCU_DATA_W   = 32;
    localparam int MCCU_COST_W   = 16;
    localparam int MCCU_PERIOD_W = 32;
    localparam int MCCU_N_CORES  = 2;

    typedef enum logic [MCCU_STATE_W-1:0] {
        MCCU_IDLE = 2'd0,
        MCCU_LOAD = 2'd1,
        MCCU_RUN  = 2'd2
    } mccu_state_e;

endpackage

// File: rtl/mccu_core_budget.sv
// Per-core remaining-budget register with saturating subtract and sticky
// budget-exceeded interrupt.
module mccu_core_budget
    import mccu_pkg::*;
#(
    parameter int DATA_WIDTH = MCCU_DATA_W,
    parameter int COST_WIDTH = MCCU_COST_W
) (
    input  logic                  clk_i,
    input  logic                  rstn_i,
    input  logic                  en,
    input  logic                  load,
    input  logic                  run,
    input  logic [DATA_WIDTH-1:0] quota_init,
    input  logic [COST_WIDTH-1:0] cost,
    input  logic                  irq_clear,
    output logic [DATA_WIDTH-1:0] remaining,
    output logic                  irq
);

    logic [DATA_WIDTH-1:0] cost_ext;
    logic                  over;

    assign cost_ext = {{(DATA_WIDTH-COST_WIDTH){1'b0}}, cost};
    assign over     = cost_ext > remaining;

    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            remaining <= '0;
            irq       <= 1'b0;
        end else begin
            if (load)
                remaining <= quota_init;
            else if (run)
                remaining <= over ? '0 : remaining - cost_ext;

            // A fresh overrun outranks a software clear in the same cycle.
            if (run && over)
                irq <= 1'b1;
            else if (en && irq_clear)
                irq <= 1'b0;
        end
    end

endmodule

// File: rtl/mccu_budget_ctrl.sv
// MCCU budget sequencer top: window FSM and period counter driving an array
// of per-core budget trackers.
module mccu_budget_ctrl
    import mccu_pkg::*;
#(
    parameter int DATA_WIDTH   = MCCU_DATA_W,
    parameter int COST_WIDTH   = MCCU_COST_W,
    parameter int PERIOD_WIDTH = MCCU_PERIOD_W,
    parameter int N_CORES      = MCCU_N_CORES
) (
    input  logic                               clk_i,
    input  logic                               rstn_i,
    input  logic                               en_i,
    input  logic                               start_i,
    input  logic                               stop_i,
    input  logic                               auto_reload_i,
    input  logic [PERIOD_WIDTH-1:0]            period_i,
    input  logic [N_CORES-1:0][DATA_WIDTH-1:0] quota_init_i,
    input  logic [N_CORES-1:0][COST_WIDTH-1:0] cost_i,
    input  logic [N_CORES-1:0]                 irq_clear_i,
    output logic [N_CORES-1:0][DATA_WIDTH-1:0] quota_remaining_o,
    output logic [N_CORES-1:0]                 interruption_quota_o,
    output logic                               period_done_o,
    output logic [MCCU_STATE_W-1:0]            state_o
);

    mccu_state_e             state, state_n;
    logic [PERIOD_WIDTH-1:0] cnt, cnt_n;
    logic                    done_q, done_n;
    logic                    load, run;

    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            state  <= MCCU_IDLE;
            cnt    <= '0;
            done_q <= 1'b0;
        end else begin
            state  <= state_n;
            cnt    <= cnt_n;
            done_q <= done_n;
        end
    end

    // Everything except the done pulse is gated by en_i; the pulse always
    // falls after one cycle so it cannot stretch while frozen.
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        done_n  = 1'b0;
        load    = 1'b0;
        run     = 1'b0;
        if (en_i) begin
            case (state)
                MCCU_IDLE: begin
                    if (start_i && !stop_i)
                        state_n = MCCU_LOAD;
                end
                MCCU_LOAD: begin
                    if (!stop_i) begin
                        load    = 1'b1;
                        cnt_n   = period_i;
                        state_n = MCCU_RUN;
                    end
                end
                MCCU_RUN: begin
                    if (!stop_i) begin
                        run = 1'b1;
                        if (cnt != '0) begin
                            cnt_n = cnt - PERIOD_WIDTH'(1);
                            if (cnt == PERIOD_WIDTH'(1)) begin
                                done_n  = 1'b1;
                                state_n = auto_reload_i ? MCCU_LOAD : MCCU_IDLE;
                            end
                        end
                    end
                end
                default: state_n = MCCU_IDLE;
            endcase
            if (stop_i)
                state_n = MCCU_IDLE;
        end
    end

    for (genvar g = 0; g < N_CORES; g++) begin : g_core
        mccu_core_budget #(
            .DATA_WIDTH (DATA_WIDTH),
            .COST_WIDTH (COST_WIDTH)
        ) u_core (
            .clk_i      (clk_i),
            .rstn_i     (rstn_i),
            .en         (en_i),
            .load       (load),
            .run        (run),
            .quota_init (quota_init_i[g]),
            .cost       (cost_i[g]),
            .irq_clear  (irq_clear_i[g]),
            .remaining  (quota_remaining_o[g]),
            .irq        (interruption_quota_o[g])
        );
    end

    assign period_done_o = done_q;
    assign state_o       = state;

endmodule
